ppe_ptr_ctrl: RTL

PPE_PTR_CTRL -- requirements
Module: ppe_ptr_ctrl

---
 rtl/ppe_ptr_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/ppe_ptr_ctrl.sv
// Pointer controller for a programmable priority encoder.
// Captures a one-hot grant, offers it to a consumer with a valid/ready handshake,
// holds it while the requester is busy, then advances the priority pointer past
// the granted index so the next arbitration round starts after the winner.
module ppe_ptr_ctrl #(
    parameter int PPE_WIDTH = 1024,
    parameter int PPE_LOG_W = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PPE_WIDTH-1:0] Gnt,
    input  logic                 valid,
    output logic [PPE_LOG_W-1:0] P_enc,
    output logic [PPE_LOG_W-1:0] gnt_idx,
    output logic                 gnt_vld,
    input  logic                 gnt_rdy,
    input  logic                 done,
    output logic                 onehot_err
);

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    state_t               state, state_nxt;
    logic [PPE_LOG_W-1:0] enc_idx;
    logic [PPE_LOG_W-1:0] idx_nxt;
    logic [PPE_LOG_W-1:0] ptr_nxt;
    logic [PPE_LOG_W-1:0] ptr_inc;
    logic                 err_nxt;
    logic                 gnt_onehot;

    // Mask of every requester position whose binary index has bit b set.
    function automatic logic [PPE_WIDTH-1:0] idx_bit_mask(input int b);
        logic [PPE_WIDTH-1:0] m;
        for (int i = 0; i < PPE_WIDTH; i++) m[i] = ((i >> b) & 1) == 1;
        return m;
    endfunction

    // One-hot to binary: each index bit is the OR of the grant lines that carry it.
    // A legal one-hot input is guaranteed, so no priority chain is needed.
    for (genvar b = 0; b < PPE_LOG_W; b++) begin : g_enc
        localparam logic [PPE_WIDTH-1:0] MASK = idx_bit_mask(b);
        assign enc_idx[b] = |(Gnt & MASK);
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign gnt_onehot = (Gnt != '0) && ((Gnt & (Gnt - PPE_WIDTH'(1))) == '0);

    // Pointer moves one past the finished winner, wrapping at the top requester.
    assign ptr_inc = (gnt_idx == PPE_LOG_W'(PPE_WIDTH - 1)) ? '0 : gnt_idx + PPE_LOG_W'(1);

    // Next-state, capture, pointer and error-flag decisions.
    always_comb begin
        state_nxt = state;
        idx_nxt   = gnt_idx;
        ptr_nxt   = P_enc;
        err_nxt   = onehot_err;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (gnt_onehot) begin
                        idx_nxt   = enc_idx;
                        state_nxt = OFFER;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            OFFER: begin
                if (gnt_rdy) state_nxt = BUSY;
            end
            BUSY: begin
                if (done) begin
                    ptr_nxt   = ptr_inc;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and output registers; gnt_vld is a registered decode of the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            P_enc      <= '0;
            gnt_idx    <= '0;
            gnt_vld    <= 1'b0;
            onehot_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            P_enc      <= ptr_nxt;
            gnt_idx    <= idx_nxt;
            gnt_vld    <= (state_nxt == OFFER);
            onehot_err <= err_nxt;
        end
    end

endmodule
